pic_control_word_sequencer: RTL and testbench
=============================================

// Module: pic_control_word_sequencer
// PURPOSE
//  Downstream of the 8259A bus control logic. Consumes its write strobes and latched internal data bus.
//  Sequences ICW1->ICW2->[ICW3]->[ICW4], routes A0=1 writes to ICW2/3/4 or OCW1 by state, decodes OCW2/OCW3.
//  Holds the programmed configuration and mask registers; issues one-cycle command pulses to the
//  in-service/priority logic.
// PARAMETERS
//  IMR_RESET_VALUE  8'hFF  interrupt_mask value after reset (all masked until programmed)
//  LOWEST_PRI_RESET 3'd7   lowest_priority_level after reset and after ICW1
// PORTS
//  clock                   in   1  system clock; all state updates on FALLING edge
//  reset                   in   1  reset, asynchronous, active-high
//  icw1_strobe             in   1  write with A0=0, D4=1
//  a0_write_strobe         in   1  any write with A0=1 (ICW2/ICW3/ICW4/OCW1, resolved here)
//  ocw2_strobe             in   1  write with A0=0, D4=0, D3=0
//  ocw3_strobe             in   1  write with A0=0, D4=0, D3=1
//  data_in                 in   8  latched internal data bus, valid while any strobe is high
//  init_in_progress        out  1  1 from ICW1 until the final ICW of the sequence is accepted
//  initialized             out  1  1 once a full ICW sequence has completed since reset
//  level_triggered         out  1  ICW1.D3 (LTIM)
//  single_mode             out  1  ICW1.D1 (SNGL)
//  vector_base             out  5  ICW2.D7:D3
//  cascade_config          out  8  ICW3 byte (slave mask, or slave ID in D2:D0)
//  mode_8086               out  1  ICW4.D0
//  auto_eoi                out  1  ICW4.D1
//  buffered_master         out  1  ICW4.D2
//  buffered_mode           out  1  ICW4.D3
//  special_fully_nested    out  1  ICW4.D4
//  interrupt_mask          out  8  OCW1 byte (IMR)
//  rotate_on_aeoi          out  1  set/cleared by OCW2
//  lowest_priority_level   out  3  priority rotation pointer
//  special_mask_mode       out  1  OCW3 SMM
//  read_isr_select         out  1  0=IRR, 1=ISR on reads
//  eoi_nonspecific         out  1  pulse
//  eoi_specific            out  8  one-hot pulse, bit L
//  rotate_nonspecific      out  1  pulse: priority logic rotates on highest ISR bit
//  poll_command            out  1  pulse, OCW3.P=1
// BEHAVIOUR
//  - Reset: state CMD_READY, IMR=IMR_RESET_VALUE, lowest=LOWEST_PRI_RESET, every other output 0.
//  - States: CMD_READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4. init_in_progress = (state != CMD_READY).
//  - icw1_strobe, any state: capture LTIM/SNGL/IC4; IMR<=8'h00; SMM<=0; read_isr_select<=0;
//    lowest<=LOWEST_PRI_RESET; rotate_on_aeoi<=0; if IC4=0 clear all ICW4 fields; ->WAIT_ICW2.
//    Takes priority over every other strobe in the same cycle; restarts a partial sequence.
//  - a0 in WAIT_ICW2: vector_base<=D7:D3; ->WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4, else CMD_READY.
//  - a0 in WAIT_ICW3: cascade_config<=D; ->WAIT_ICW4 if IC4 else CMD_READY. SNGL=1 leaves cascade_config.
//  - a0 in WAIT_ICW4: capture D4:D0; ->CMD_READY. Entering CMD_READY from WAIT_* sets initialized=1.
//  - a0 in CMD_READY: interrupt_mask<=D (OCW1).
//  - ocw2/ocw3 strobes while init_in_progress: ignored, no state change, no pulses.
//  - OCW2 D7:D5 (R,SL,EOI), L=D2:D0:
//    001 eoi_nonspecific; 011 eoi_specific[L]; 101 eoi_nonspecific+rotate_nonspecific;
//    100 rotate_on_aeoi<=1; 000 rotate_on_aeoi<=0; 111 eoi_specific[L]+lowest<=L;
//    110 lowest<=L; 010 no action.
//  - OCW3: if D6 then SMM<=D5; if D1 then read_isr_select<=D0; if D2 poll_command pulse.
//    D2=1 and D1=1 together: both take effect.
//  - Latency: strobe sampled at falling edge N; registers and pulses change at edge N.
//    Pulses high for exactly one clock period; strobes held 2+ cycles produce one action per sampled cycle.
//  - Reset mid-sequence: returns to CMD_READY with reset values; initialized=0.
// STRUCTURE
//  - Package pic_8259_pkg: state enum; OCW2 command codes (3-bit localparams);
//    ICW1/ICW4/OCW3 bit-index constants.
//  - Sub-module pic_ocw2_decoder (combinational): D7:D0 -> action pulses and lowest-priority load.
//  - FSM and registers stay in this module.
// TESTING
//  - ICW1=8'h1B, ICW2=8'h40, ICW4=8'h03 -> vector_base=5'h08; level_triggered=1; single_mode=1;
//    auto_eoi=1; mode_8086=1; ICW3 skipped; initialized=1.
//  - ICW1=8'h11, ICW2=8'h20, ICW3=8'h04, ICW4=8'h1D -> cascade_config=8'h04; special_fully_nested=1;
//    buffered_mode=1; buffered_master=1; then A0 write 8'hF0 -> interrupt_mask=8'hF0.
//  - ICW1 during WAIT_ICW3 -> back to WAIT_ICW2; IMR=0; cascade_config unchanged; initialized unchanged.
//  - OCW2=8'h63 -> eoi_specific=8'h08 for one cycle; OCW2=8'hC5 -> lowest_priority_level=5, no pulse.
//  - OCW3=8'h6B -> special_mask_mode=1, read_isr_select=1; OCW3=8'h0C -> poll_command pulse, RR unchanged.
//  - OCW2 during init -> no pulse; ICW1+OCW3 same cycle -> ICW1 only; reset mid-ICW2 -> IMR=8'hFF,
//    state CMD_READY.

Source files
------------

// File: rtl/pic_8259_pkg.sv
// Shared types and bit positions for the 8259A control-word sequencer.
// Holds the sequencer states, the OCW2 command codes and the ICW/OCW field indices.
package pic_8259_pkg;

    typedef enum logic [1:0] {
        CMD_READY = 2'd0,
        WAIT_ICW2 = 2'd1,
        WAIT_ICW3 = 2'd2,
        WAIT_ICW4 = 2'd3
    } pic_state_t;

    // OCW2 D7:D5 = R, SL, EOI
    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SPEC_EOI     = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
    localparam logic [2:0] OCW2_ROT_SPEC_EOI = 3'b111;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_LTIM = 3;

    localparam int ICW4_UPM  = 0;
    localparam int ICW4_AEOI = 1;
    localparam int ICW4_MS   = 2;
    localparam int ICW4_BUF  = 3;
    localparam int ICW4_SFNM = 4;

    localparam int OCW3_RIS  = 0;
    localparam int OCW3_RR   = 1;
    localparam int OCW3_P    = 2;
    localparam int OCW3_SMM  = 5;
    localparam int OCW3_ESMM = 6;

endpackage

// File: rtl/pic_ocw2_decoder.sv
// Combinational OCW2 decode: command code and level to EOI/rotate actions.
// The sequencer registers these, so nothing here is stateful.
module pic_ocw2_decoder
    import pic_8259_pkg::*;
(
    input  logic [2:0] command,
    input  logic [2:0] level,
    output logic       eoi_nonspecific,
    output logic [7:0] eoi_specific,
    output logic       rotate_nonspecific,
    output logic       rotate_aeoi_set,
    output logic       rotate_aeoi_clear,
    output logic       load_lowest
);

    always_comb begin
        eoi_nonspecific    = 1'b0;
        eoi_specific       = 8'h00;
        rotate_nonspecific = 1'b0;
        rotate_aeoi_set    = 1'b0;
        rotate_aeoi_clear  = 1'b0;
        load_lowest        = 1'b0;
        case (command)
            OCW2_ROT_AEOI_CLR: rotate_aeoi_clear = 1'b1;
            OCW2_NS_EOI:       eoi_nonspecific = 1'b1;
            OCW2_NOP:          ;
            OCW2_SPEC_EOI:     eoi_specific = 8'h01 << level;
            OCW2_ROT_AEOI_SET: rotate_aeoi_set = 1'b1;
            OCW2_ROT_NS_EOI: begin
                eoi_nonspecific    = 1'b1;
                rotate_nonspecific = 1'b1;
            end
            OCW2_SET_PRI:      load_lowest = 1'b1;
            OCW2_ROT_SPEC_EOI: begin
                eoi_specific = 8'h01 << level;
                load_lowest  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pic_control_word_sequencer.sv
// 8259A control-word sequencer: walks ICW1..ICW4, holds configuration and IMR,
// and turns OCW2/OCW3 writes into one-cycle command pulses. Updates on the falling edge.
module pic_control_word_sequencer
    import pic_8259_pkg::*;
#(
    parameter logic [7:0] IMR_RESET_VALUE  = 8'hFF,
    parameter logic [2:0] LOWEST_PRI_RESET = 3'd7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       icw1_strobe,
    input  logic       a0_write_strobe,
    input  logic       ocw2_strobe,
    input  logic       ocw3_strobe,
    input  logic [7:0] data_in,
    output logic       init_in_progress,
    output logic       initialized,
    output logic       level_triggered,
    output logic       single_mode,
    output logic [4:0] vector_base,
    output logic [7:0] cascade_config,
    output logic       mode_8086,
    output logic       auto_eoi,
    output logic       buffered_master,
    output logic       buffered_mode,
    output logic       special_fully_nested,
    output logic [7:0] interrupt_mask,
    output logic       rotate_on_aeoi,
    output logic [2:0] lowest_priority_level,
    output logic       special_mask_mode,
    output logic       read_isr_select,
    output logic       eoi_nonspecific,
    output logic [7:0] eoi_specific,
    output logic       rotate_nonspecific,
    output logic       poll_command
);

    pic_state_t state, next_state;
    logic       icw4_needed;
    logic       ocw2_accept, ocw3_accept, entering_ready;

    logic       dec_eoi_nonspecific, dec_rotate_nonspecific;
    logic [7:0] dec_eoi_specific;
    logic       dec_rotate_aeoi_set, dec_rotate_aeoi_clear, dec_load_lowest;

    pic_ocw2_decoder u_ocw2_decoder (
        .command            (data_in[7:5]),
        .level              (data_in[2:0]),
        .eoi_nonspecific    (dec_eoi_nonspecific),
        .eoi_specific       (dec_eoi_specific),
        .rotate_nonspecific (dec_rotate_nonspecific),
        .rotate_aeoi_set    (dec_rotate_aeoi_set),
        .rotate_aeoi_clear  (dec_rotate_aeoi_clear),
        .load_lowest        (dec_load_lowest)
    );

    always_ff @(negedge clock or posedge reset) begin
        if (reset) state <= CMD_READY;
        else       state <= next_state;
    end

    // ICW1 restarts the sequence from any state; SNGL/IC4 come from the latched ICW1.
    always_comb begin
        next_state = state;
        if (icw1_strobe) begin
            next_state = WAIT_ICW2;
        end else if (a0_write_strobe) begin
            case (state)
                WAIT_ICW2: begin
                    if (!single_mode)     next_state = WAIT_ICW3;
                    else if (icw4_needed) next_state = WAIT_ICW4;
                    else                  next_state = CMD_READY;
                end
                WAIT_ICW3: next_state = icw4_needed ? WAIT_ICW4 : CMD_READY;
                WAIT_ICW4: next_state = CMD_READY;
                default:   next_state = CMD_READY;
            endcase
        end
    end

    always_comb begin
        init_in_progress = (state != CMD_READY);
        entering_ready   = (state != CMD_READY) && (next_state == CMD_READY);
        ocw2_accept      = ocw2_strobe && !icw1_strobe && (state == CMD_READY);
        ocw3_accept      = ocw3_strobe && !icw1_strobe && (state == CMD_READY);
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            initialized           <= 1'b0;
            level_triggered       <= 1'b0;
            single_mode           <= 1'b0;
            icw4_needed           <= 1'b0;
            vector_base           <= 5'd0;
            cascade_config        <= 8'h00;
            mode_8086             <= 1'b0;
            auto_eoi              <= 1'b0;
            buffered_master       <= 1'b0;
            buffered_mode         <= 1'b0;
            special_fully_nested  <= 1'b0;
            interrupt_mask        <= IMR_RESET_VALUE;
            rotate_on_aeoi        <= 1'b0;
            lowest_priority_level <= LOWEST_PRI_RESET;
            special_mask_mode     <= 1'b0;
            read_isr_select       <= 1'b0;
            eoi_nonspecific       <= 1'b0;
            eoi_specific          <= 8'h00;
            rotate_nonspecific    <= 1'b0;
            poll_command          <= 1'b0;
        end else begin
            initialized        <= initialized | entering_ready;
            eoi_nonspecific    <= ocw2_accept & dec_eoi_nonspecific;
            eoi_specific       <= ocw2_accept ? dec_eoi_specific : 8'h00;
            rotate_nonspecific <= ocw2_accept & dec_rotate_nonspecific;
            poll_command       <= ocw3_accept & data_in[OCW3_P];

            if (icw1_strobe) begin
                level_triggered       <= data_in[ICW1_LTIM];
                single_mode           <= data_in[ICW1_SNGL];
                icw4_needed           <= data_in[ICW1_IC4];
                interrupt_mask        <= 8'h00;
                special_mask_mode     <= 1'b0;
                read_isr_select       <= 1'b0;
                lowest_priority_level <= LOWEST_PRI_RESET;
                rotate_on_aeoi        <= 1'b0;
                if (!data_in[ICW1_IC4]) begin
                    mode_8086            <= 1'b0;
                    auto_eoi             <= 1'b0;
                    buffered_master      <= 1'b0;
                    buffered_mode        <= 1'b0;
                    special_fully_nested <= 1'b0;
                end
            end else begin
                if (a0_write_strobe) begin
                    case (state)
                        WAIT_ICW2: vector_base    <= data_in[7:3];
                        WAIT_ICW3: cascade_config <= data_in;
                        WAIT_ICW4: begin
                            mode_8086            <= data_in[ICW4_UPM];
                            auto_eoi             <= data_in[ICW4_AEOI];
                            buffered_master      <= data_in[ICW4_MS];
                            buffered_mode        <= data_in[ICW4_BUF];
                            special_fully_nested <= data_in[ICW4_SFNM];
                        end
                        default:   interrupt_mask <= data_in;
                    endcase
                end
                if (ocw2_accept) begin
                    if (dec_rotate_aeoi_set)   rotate_on_aeoi <= 1'b1;
                    if (dec_rotate_aeoi_clear) rotate_on_aeoi <= 1'b0;
                    if (dec_load_lowest)       lowest_priority_level <= data_in[2:0];
                end
                if (ocw3_accept) begin
                    if (data_in[OCW3_ESMM]) special_mask_mode <= data_in[OCW3_SMM];
                    if (data_in[OCW3_RR])   read_isr_select   <= data_in[OCW3_RIS];
                end
            end
        end
    end

endmodule

// File: tb/tb_pic_control_word_sequencer.sv
// Directed bench for the control-word sequencer: drives on the rising edge,
// DUT acts on the falling edge, outputs are checked on the following rising edge.
module tb_pic_control_word_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       icw1_strobe = 1'b0, a0_write_strobe = 1'b0;
    logic       ocw2_strobe = 1'b0, ocw3_strobe = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic       init_in_progress, initialized, level_triggered, single_mode;
    logic [4:0] vector_base;
    logic [7:0] cascade_config;
    logic       mode_8086, auto_eoi, buffered_master, buffered_mode, special_fully_nested;
    logic [7:0] interrupt_mask;
    logic       rotate_on_aeoi;
    logic [2:0] lowest_priority_level;
    logic       special_mask_mode, read_isr_select, eoi_nonspecific;
    logic [7:0] eoi_specific;
    logic       rotate_nonspecific, poll_command;

    int errorCount = 0;
    int checkCount = 0;

    localparam logic [3:0] S_ICW1 = 4'b0001;
    localparam logic [3:0] S_A0   = 4'b0010;
    localparam logic [3:0] S_OCW2 = 4'b0100;
    localparam logic [3:0] S_OCW3 = 4'b1000;

    pic_control_word_sequencer dut (
        .clock                 (clock),
        .reset                 (reset),
        .icw1_strobe           (icw1_strobe),
        .a0_write_strobe       (a0_write_strobe),
        .ocw2_strobe           (ocw2_strobe),
        .ocw3_strobe           (ocw3_strobe),
        .data_in               (data_in),
        .init_in_progress      (init_in_progress),
        .initialized           (initialized),
        .level_triggered       (level_triggered),
        .single_mode           (single_mode),
        .vector_base           (vector_base),
        .cascade_config        (cascade_config),
        .mode_8086             (mode_8086),
        .auto_eoi              (auto_eoi),
        .buffered_master       (buffered_master),
        .buffered_mode         (buffered_mode),
        .special_fully_nested  (special_fully_nested),
        .interrupt_mask        (interrupt_mask),
        .rotate_on_aeoi        (rotate_on_aeoi),
        .lowest_priority_level (lowest_priority_level),
        .special_mask_mode     (special_mask_mode),
        .read_isr_select       (read_isr_select),
        .eoi_nonspecific       (eoi_nonspecific),
        .eoi_specific          (eoi_specific),
        .rotate_nonspecific    (rotate_nonspecific),
        .poll_command          (poll_command)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // One write: strobes high across exactly one falling edge, then released.
    task automatic applyStimulus(input logic [3:0] strobes, input logic [7:0] data);
        @(posedge clock);
        icw1_strobe     = strobes[0];
        a0_write_strobe = strobes[1];
        ocw2_strobe     = strobes[2];
        ocw3_strobe     = strobes[3];
        data_in         = data;
        @(posedge clock);
        icw1_strobe     = 1'b0;
        a0_write_strobe = 1'b0;
        ocw2_strobe     = 1'b0;
        ocw3_strobe     = 1'b0;
        #1;
    endtask

    task automatic idleCycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        reset = 1'b0;
        #1;
        checkOutput("reset_imr", 32'(interrupt_mask), 32'hFF);
        checkOutput("reset_lowest", 32'(lowest_priority_level), 32'd7);
        checkOutput("reset_init_busy", 32'(init_in_progress), 32'd0);
        checkOutput("reset_initialized", 32'(initialized), 32'd0);
        checkOutput("reset_vector", 32'(vector_base), 32'd0);

        // Single mode with ICW4, no ICW3
        applyStimulus(S_ICW1, 8'h1B);
        checkOutput("t1_busy", 32'(init_in_progress), 32'd1);
        checkOutput("t1_ltim", 32'(level_triggered), 32'd1);
        checkOutput("t1_sngl", 32'(single_mode), 32'd1);
        checkOutput("t1_imr_clr", 32'(interrupt_mask), 32'h00);
        applyStimulus(S_A0, 8'h40);
        checkOutput("t1_vector", 32'(vector_base), 32'h08);
        checkOutput("t1_busy_icw4", 32'(init_in_progress), 32'd1);
        applyStimulus(S_A0, 8'h03);
        checkOutput("t1_aeoi", 32'(auto_eoi), 32'd1);
        checkOutput("t1_8086", 32'(mode_8086), 32'd1);
        checkOutput("t1_done", 32'(init_in_progress), 32'd0);
        checkOutput("t1_initialized", 32'(initialized), 32'd1);
        checkOutput("t1_cascade", 32'(cascade_config), 32'h00);

        // Cascade mode with ICW3 and ICW4, then OCW1
        applyStimulus(S_ICW1, 8'h11);
        checkOutput("t2_ltim", 32'(level_triggered), 32'd0);
        checkOutput("t2_sngl", 32'(single_mode), 32'd0);
        checkOutput("t2_initialized_kept", 32'(initialized), 32'd1);
        applyStimulus(S_A0, 8'h20);
        checkOutput("t2_vector", 32'(vector_base), 32'h04);
        applyStimulus(S_A0, 8'h04);
        checkOutput("t2_cascade", 32'(cascade_config), 32'h04);
        checkOutput("t2_busy_icw4", 32'(init_in_progress), 32'd1);
        applyStimulus(S_A0, 8'h1D);
        checkOutput("t2_sfnm", 32'(special_fully_nested), 32'd1);
        checkOutput("t2_buf", 32'(buffered_mode), 32'd1);
        checkOutput("t2_ms", 32'(buffered_master), 32'd1);
        checkOutput("t2_8086", 32'(mode_8086), 32'd1);
        checkOutput("t2_aeoi", 32'(auto_eoi), 32'd0);
        checkOutput("t2_done", 32'(init_in_progress), 32'd0);
        applyStimulus(S_A0, 8'hF0);
        checkOutput("t2_ocw1", 32'(interrupt_mask), 32'hF0);

        // ICW1 restarts a partial sequence sitting in WAIT_ICW3
        applyStimulus(S_ICW1, 8'h11);
        applyStimulus(S_A0, 8'h20);
        applyStimulus(S_ICW1, 8'h11);
        checkOutput("t3_busy", 32'(init_in_progress), 32'd1);
        checkOutput("t3_imr", 32'(interrupt_mask), 32'h00);
        checkOutput("t3_cascade_kept", 32'(cascade_config), 32'h04);
        checkOutput("t3_initialized_kept", 32'(initialized), 32'd1);
        applyStimulus(S_A0, 8'h48);
        checkOutput("t3_vector", 32'(vector_base), 32'h09);
        applyStimulus(S_A0, 8'h08);
        checkOutput("t3_cascade_new", 32'(cascade_config), 32'h08);
        applyStimulus(S_A0, 8'h1D);
        checkOutput("t3_done", 32'(init_in_progress), 32'd0);

        // OCW2 commands
        applyStimulus(S_OCW2, 8'h63);
        checkOutput("ocw2_spec_eoi", 32'(eoi_specific), 32'h08);
        checkOutput("ocw2_spec_no_ns", 32'(eoi_nonspecific), 32'd0);
        idleCycle();
        checkOutput("ocw2_spec_gone", 32'(eoi_specific), 32'h00);
        applyStimulus(S_OCW2, 8'hC5);
        checkOutput("ocw2_setpri", 32'(lowest_priority_level), 32'd5);
        checkOutput("ocw2_setpri_nopulse", 32'(eoi_specific), 32'h00);
        applyStimulus(S_OCW2, 8'hA0);
        checkOutput("ocw2_rot_ns_eoi", 32'(eoi_nonspecific), 32'd1);
        checkOutput("ocw2_rot_ns_rot", 32'(rotate_nonspecific), 32'd1);
        idleCycle();
        checkOutput("ocw2_rot_ns_gone", 32'(rotate_nonspecific), 32'd0);
        applyStimulus(S_OCW2, 8'h80);
        checkOutput("ocw2_aeoi_set", 32'(rotate_on_aeoi), 32'd1);
        applyStimulus(S_OCW2, 8'hE2);
        checkOutput("ocw2_rot_spec", 32'(eoi_specific), 32'h04);
        checkOutput("ocw2_rot_spec_pri", 32'(lowest_priority_level), 32'd2);
        applyStimulus(S_OCW2, 8'h20);
        checkOutput("ocw2_ns_eoi", 32'(eoi_nonspecific), 32'd1);
        checkOutput("ocw2_ns_no_rot", 32'(rotate_nonspecific), 32'd0);
        applyStimulus(S_OCW2, 8'h00);
        checkOutput("ocw2_aeoi_clr", 32'(rotate_on_aeoi), 32'd0);
        checkOutput("ocw2_aeoi_clr_nopulse", 32'(eoi_nonspecific), 32'd0);

        // OCW3
        applyStimulus(S_OCW3, 8'h6B);
        checkOutput("ocw3_smm", 32'(special_mask_mode), 32'd1);
        checkOutput("ocw3_ris", 32'(read_isr_select), 32'd1);
        checkOutput("ocw3_no_poll", 32'(poll_command), 32'd0);
        applyStimulus(S_OCW3, 8'h0C);
        checkOutput("ocw3_poll", 32'(poll_command), 32'd1);
        checkOutput("ocw3_ris_kept", 32'(read_isr_select), 32'd1);
        checkOutput("ocw3_smm_kept", 32'(special_mask_mode), 32'd1);
        idleCycle();
        checkOutput("ocw3_poll_gone", 32'(poll_command), 32'd0);

        // OCW2 ignored during init; ICW1 clears OCW3 state
        applyStimulus(S_ICW1, 8'h13);
        checkOutput("t6_smm_clr", 32'(special_mask_mode), 32'd0);
        checkOutput("t6_ris_clr", 32'(read_isr_select), 32'd0);
        checkOutput("t6_lowest", 32'(lowest_priority_level), 32'd7);
        applyStimulus(S_OCW2, 8'h20);
        checkOutput("t6_ocw2_ignored", 32'(eoi_nonspecific), 32'd0);
        checkOutput("t6_still_busy", 32'(init_in_progress), 32'd1);
        applyStimulus(S_A0, 8'h40);
        applyStimulus(S_A0, 8'h01);
        checkOutput("t6_done", 32'(init_in_progress), 32'd0);

        // ICW1 and OCW3 in the same cycle: only ICW1 acts
        applyStimulus(S_ICW1 | S_OCW3, 8'h1F);
        checkOutput("t7_icw1_wins_busy", 32'(init_in_progress), 32'd1);
        checkOutput("t7_icw1_wins_ltim", 32'(level_triggered), 32'd1);
        checkOutput("t7_no_poll", 32'(poll_command), 32'd0);
        checkOutput("t7_no_ris", 32'(read_isr_select), 32'd0);

        // Reset while waiting for ICW2
        @(posedge clock);
        reset = 1'b1;
        @(posedge clock);
        reset = 1'b0;
        #1;
        checkOutput("t8_imr", 32'(interrupt_mask), 32'hFF);
        checkOutput("t8_ready", 32'(init_in_progress), 32'd0);
        checkOutput("t8_initialized", 32'(initialized), 32'd0);
        checkOutput("t8_ltim", 32'(level_triggered), 32'd0);
        checkOutput("t8_lowest", 32'(lowest_priority_level), 32'd7);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
